// File: rtl/level_alarm_classifier.sv
// Classifies filtered level samples into a registered 3-bit alarm code with
// hysteresis, N-sample persistence and a stalled-stream timeout.
module level_alarm_classifier #(
    parameter int LEVEL_W   = 12,
    parameter int LOW_SET   = 400,
    parameter int LOW_CLR   = 500,
    parameter int HIGH_SET  = 3600,
    parameter int HIGH_CLR  = 3500,
    parameter int MAX_VALID = 4000,
    parameter int PERSIST   = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] level,
    input  logic               sensor_fault,
    output logic [2:0]         alarm_code,
    output logic               alarm_changed,
    output logic               alarm_active
);
    localparam int PW = $clog2(PERSIST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [LEVEL_W-1:0] LOW_SET_L   = LEVEL_W'(LOW_SET);
    localparam logic [LEVEL_W-1:0] LOW_CLR_L   = LEVEL_W'(LOW_CLR);
    localparam logic [LEVEL_W-1:0] HIGH_SET_L  = LEVEL_W'(HIGH_SET);
    localparam logic [LEVEL_W-1:0] HIGH_CLR_L  = LEVEL_W'(HIGH_CLR);
    localparam logic [LEVEL_W-1:0] MAX_VALID_L = LEVEL_W'(MAX_VALID);
    localparam logic [PW-1:0]      PERSIST_C   = PW'(PERSIST);
    localparam logic [TW-1:0]      TIMEOUT_C   = TW'(TIMEOUT);
    localparam logic [TW-1:0]      TIMEOUT_M1  = TW'(TIMEOUT - 1);

    localparam logic [2:0] CODE_OK    = 3'b000;
    localparam logic [2:0] CODE_LOW   = 3'b001;
    localparam logic [2:0] CODE_HIGH  = 3'b010;
    localparam logic [2:0] CODE_FAULT = 3'b100;
    localparam logic [2:0] CODE_TMO   = 3'b101;
    localparam logic [2:0] CODE_RANGE = 3'b110;

    typedef enum logic [1:0] {ST_OK, ST_LOW, ST_HIGH, ST_ERR} state_t;
    typedef enum logic [1:0] {C_NONE, C_OK, C_LOW, C_HIGH} cand_t;

    state_t        state_q, state_d;
    logic [2:0]    err_q, err_d;
    cand_t         cand_q, cand_d, cand;
    logic [PW-1:0] pcnt_q, pcnt_d, cnt_new;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    code_d;

    logic lvl_low, lvl_high, lvl_clr_low, lvl_clr_high, lvl_oor;

    assign lvl_low      = (level <= LOW_SET_L);
    assign lvl_high     = (level >= HIGH_SET_L);
    assign lvl_clr_low  = (level >= LOW_CLR_L);
    assign lvl_clr_high = (level <= HIGH_CLR_L);
    assign lvl_oor      = (level >  MAX_VALID_L);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cand_d  = cand_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        cand    = C_NONE;
        cnt_new = '0;

        // Hysteresis: each state only looks at the thresholds that leave it.
        case (state_q)
            ST_OK: begin
                if (lvl_low)       cand = C_LOW;
                else if (lvl_high) cand = C_HIGH;
            end
            ST_LOW: begin
                if (lvl_high)         cand = C_HIGH;
                else if (lvl_clr_low) cand = C_OK;
            end
            ST_HIGH: begin
                if (lvl_low)           cand = C_LOW;
                else if (lvl_clr_high) cand = C_OK;
            end
            default: begin
                if (lvl_low)       cand = C_LOW;
                else if (lvl_high) cand = C_HIGH;
                else               cand = C_OK;
            end
        endcase

        if (sample_valid) begin
            tcnt_d = '0;
            if (sensor_fault) begin
                state_d = ST_ERR;
                err_d   = CODE_FAULT;
                pcnt_d  = '0;
                cand_d  = C_NONE;
            end else if (lvl_oor) begin
                state_d = ST_ERR;
                err_d   = CODE_RANGE;
                pcnt_d  = '0;
                cand_d  = C_NONE;
            end else if (cand == C_NONE) begin
                pcnt_d = '0;
                cand_d = C_NONE;
            end else begin
                cnt_new = (cand == cand_q) ? pcnt_q + PW'(1) : PW'(1);
                if (cnt_new == PERSIST_C) begin
                    case (cand)
                        C_LOW:   state_d = ST_LOW;
                        C_HIGH:  state_d = ST_HIGH;
                        default: state_d = ST_OK;
                    endcase
                    pcnt_d = '0;
                    cand_d = C_NONE;
                end else begin
                    pcnt_d = cnt_new;
                    cand_d = cand;
                end
            end
        end else begin
            if (tcnt_q != TIMEOUT_C) tcnt_d = tcnt_q + TW'(1);
            // Fault and range errors outrank a stalled stream.
            if (tcnt_q == TIMEOUT_M1 &&
                !(state_q == ST_ERR && err_q != CODE_TMO)) begin
                state_d = ST_ERR;
                err_d   = CODE_TMO;
            end
        end
    end

    always_comb begin
        code_d = CODE_OK;
        case (state_d)
            ST_LOW:  code_d = CODE_LOW;
            ST_HIGH: code_d = CODE_HIGH;
            ST_ERR:  code_d = err_d;
            default: code_d = CODE_OK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_OK;
            err_q         <= CODE_OK;
            cand_q        <= C_NONE;
            pcnt_q        <= '0;
            tcnt_q        <= '0;
            alarm_code    <= CODE_OK;
            alarm_changed <= 1'b0;
            alarm_active  <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            cand_q        <= cand_d;
            pcnt_q        <= pcnt_d;
            tcnt_q        <= tcnt_d;
            alarm_code    <= code_d;
            alarm_changed <= (code_d != alarm_code);
            alarm_active  <= (code_d != CODE_OK);
        end
    end
endmodule

// File: doc/level_alarm_classifier.md
Name: level_alarm_classifier

Overview:
- Upstream stage of the 7-segment alarm display decoder.
- Classifies filtered liquid-level samples into a registered 3-bit alarm code:
  - 000 OK, 001 LOW, 010 HIGH
  - 100 sensor fault, 101 sample timeout, 110 out-of-range
- Applies hysteresis and N-sample persistence so the display does not flicker, and watches for a stalled sample stream.

Parameters:
- LEVEL_W, 12, width of level sample
- LOW_SET, 400, level <= this qualifies LOW
- LOW_CLR, 500, level >= this clears LOW (must be > LOW_SET)
- HIGH_SET, 3600, level >= this qualifies HIGH
- HIGH_CLR, 3500, level <= this clears HIGH (must be < HIGH_SET, > LOW_CLR)
- MAX_VALID, 4000, level > this is out-of-range
- PERSIST, 4, consecutive qualifying samples required for any level/recovery transition (>= 1)
- TIMEOUT, 1000, cycles without sample_valid before timeout error (>= 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  reset, synchronous, active-high
- sample_valid  input  1  one-cycle strobe qualifying level and sensor_fault
- level  input  LEVEL_W  unsigned level sample
- sensor_fault  input  1  sensor fault flag, sampled only with sample_valid
- alarm_code  output  3  registered alarm code, feeds the display decoder
- alarm_changed  output  1  one-cycle pulse when alarm_code changes value
- alarm_active  output  1  registered, 1 whenever alarm_code != 000

Behaviour:
- Reset (any cycle, overrides everything):
  - state OK; alarm_code=000, alarm_changed=0, alarm_active=0
  - persistence counter and timeout counter cleared
- States: OK, LOW, HIGH, ERR. ERR carries a sub-code: 100, 101 or 110.
- Latency: outputs update on the clock edge that samples the deciding input, visible the following cycle. alarm_changed asserts in that same cycle only.
- Per valid sample, priority (highest first):
  1. sensor_fault=1 -> ERR/100 immediately; persistence counter cleared.
  2. level > MAX_VALID -> ERR/110 immediately; counter cleared.
  3. Threshold classification (below).
- Threshold classification by state:
  - OK: candidate LOW if level <= LOW_SET; candidate HIGH if level >= HIGH_SET; else no candidate.
  - LOW: candidate HIGH if level >= HIGH_SET; candidate OK if level >= LOW_CLR; else none.
  - HIGH: candidate LOW if level <= LOW_SET; candidate OK if level <= HIGH_CLR; else none.
  - ERR: sample is "good" if no fault and level <= MAX_VALID. The candidate is the OK-state classification of that sample using SET thresholds only, with OK if neither SET threshold is met.
- Persistence:
  - The counter increments on each valid sample whose candidate equals the previous sample's candidate.
  - It resets to 1 on a new candidate and to 0 on no candidate.
  - The transition fires when the count reaches PERSIST, then the counter clears.
  - Cycles without sample_valid leave the counter untouched.
  - PERSIST=1 means a single sample transitions.
- Fault or range while already in ERR updates the sub-code to the newest cause. Same-code repeats do not pulse alarm_changed.
- Timeout:
  - The counter clears on every sample_valid and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: enter ERR/101 from any state, unless already ERR/100 or ERR/110; those keep their code.
  - Recovery from 101 follows the normal ERR recovery rule.
- A sample_valid in the same cycle the timeout counter would reach TIMEOUT wins: no timeout.
- Hysteresis band values (LOW_SET < level < LOW_CLR while LOW, etc.) hold the current state and produce no candidate.
- No arithmetic beyond unsigned compares. Counters are sized by $clog2(PERSIST+1) and $clog2(TIMEOUT+1).

Test Plan:
- Reset then 4 valid samples of 2000 -> alarm_code stays 000, alarm_changed never pulses.
- From OK, samples 350,350,350 then 2000 -> stays 000. Then 4x350 -> code 001 one cycle after the 4th sample, alarm_changed=1 for exactly one cycle, alarm_active=1.
- In LOW:
  - 4x450 -> stays 001 (hysteresis band).
  - 4x520 -> 000.
  - From OK, 4x3700 -> 010.
  - 4x3550 -> stays 010.
  - 4x3400 -> 000.
- sensor_fault=1 on one valid sample while HIGH -> 100 next cycle. Then 3 good samples of 2000 -> still 100. 4th good sample -> 000.
- Level 4095 on one sample -> 110 immediately. Then sensor_fault sample -> 100 with alarm_changed pulse.
- No sample_valid for 999 cycles then a sample -> no timeout. Then 1000 idle cycles -> 101. Reset asserted mid-ERR -> 000 and all counters cleared next cycle.
